// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - single-bit debounce with rise/fall/long-hold pulses and glitch counter
// A new din level must persist for STABLE ce-ticks before dout follows; aborted checks are counted.
module sync_debounce #(
   parameter int STABLE   = 4,
   parameter int HOLD     = 10,
   parameter int CNT_W    = 16,
   parameter int GLITCH_W = 8,
   parameter int INIT     = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din,
   input  logic                ce,
   input  logic                glitch_clr,
   output logic                dout,
   output logic                rise,
   output logic                fall,
   output logic                hold,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_CHK_HIGH = 2'd1,
      S_HIGH     = 2'd2,
      S_CHK_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]    STABLE_M1 = CNT_W'(STABLE - 1);
   localparam logic [CNT_W-1:0]    HOLD_M1   = (HOLD > 0) ? CNT_W'(HOLD - 1) : '0;
   localparam logic                HOLD_EN   = (HOLD > 0);
   localparam logic                INIT_LVL  = (INIT != 0);
   localparam state_t              INIT_ST   = (INIT != 0) ? S_HIGH : S_LOW;
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    scnt_q, scnt_d;
   logic [CNT_W-1:0]    hcnt_q, hcnt_d;
   logic                hflag_q, hflag_d;
   logic                dout_q, dout_d;
   logic                rise_q, rise_d;
   logic                fall_q, fall_d;
   logic                hold_q, hold_d;
   logic [GLITCH_W-1:0] gcnt_q, gcnt_d;
   logic                glitch_ev;
   logic                stable_done;

   assign stable_done = ce && (scnt_q == STABLE_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT_ST;
         scnt_q  <= '0;
         hcnt_q  <= '0;
         hflag_q <= 1'b0;
         dout_q  <= INIT_LVL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         hold_q  <= 1'b0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         hcnt_q  <= hcnt_d;
         hflag_q <= hflag_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         hold_q  <= hold_d;
         gcnt_q  <= gcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      case (state_q)
         S_LOW: begin
            if (din) begin
               state_d = S_CHK_HIGH;
               scnt_d  = '0;
            end
         end
         S_CHK_HIGH: begin
            if (!din) begin
               state_d = S_LOW;
            end else if (stable_done) begin
               state_d = S_HIGH;
            end else if (ce) begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         S_HIGH: begin
            if (!din) begin
               state_d = S_CHK_LOW;
               scnt_d  = '0;
            end
         end
         S_CHK_LOW: begin
            if (din) begin
               state_d = S_HIGH;
            end else if (stable_done) begin
               state_d = S_LOW;
            end else if (ce) begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         default: begin
            state_d = INIT_ST;
            scnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      dout_d    = dout_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      glitch_ev = 1'b0;
      case (state_q)
         S_CHK_HIGH: begin
            if (!din) begin
               glitch_ev = 1'b1;
            end else if (stable_done) begin
               dout_d = 1'b1;
               rise_d = 1'b1;
            end
         end
         S_CHK_LOW: begin
            if (din) begin
               glitch_ev = 1'b1;
            end else if (stable_done) begin
               dout_d = 1'b0;
               fall_d = 1'b1;
            end
         end
         default: begin
            dout_d = dout_q;
         end
      endcase

      gcnt_d = gcnt_q;
      if (glitch_clr) begin
         gcnt_d = '0;
      end else if (glitch_ev && (gcnt_q != GLITCH_MAX)) begin
         gcnt_d = gcnt_q + 1'b1;
      end

      // Clearing on the falling edge itself keeps hold and fall mutually exclusive.
      hcnt_d  = hcnt_q;
      hflag_d = hflag_q;
      hold_d  = 1'b0;
      if (!dout_d) begin
         hcnt_d  = '0;
         hflag_d = 1'b0;
      end else if (HOLD_EN && dout_q && ce && !hflag_q) begin
         if (hcnt_q == HOLD_M1) begin
            hold_d  = 1'b1;
            hflag_d = 1'b1;
         end else begin
            hcnt_d = hcnt_q + 1'b1;
         end
      end
   end

   assign dout       = dout_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign hold       = hold_q;
   assign glitch_cnt = gcnt_q;

endmodule
